qam16_tx_ctrl: RTL and testbench
================================

Name: qam16_tx_ctrl

Overview:
Framing and symbol-sequencing controller for the 16QAM modulator datapath.
- Accepts payload bytes over a valid/ready handshake and splits each byte into two 4-bit symbol codes, high nibble first.
- Wraps each frame with a fixed preamble and an idle gap.
- Presents one code per symbol period, plus the derived I/Q 2-bit signed levels, to the I/Q multiplier stage.
- Replaces the free-running data source and serial-to-parallel path with a rate-controlled, framed source.

Parameters:
SYM_PERIOD, 16, clocks per symbol (>=2)
PRE_LEN, 8, preamble symbols per frame (>=1)
FRAME_BYTES, 32, payload bytes per frame (>=1); payload = 2*FRAME_BYTES symbols
GAP_LEN, 4, idle symbols after each frame (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits starting a new frame; an ongoing frame is unaffected
in_data  input  8  payload byte
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty; byte accepted when in_valid & in_ready
code_out  output  4  current symbol code {b3,b2,b1,b0}
signal_I  output  2  signed I level = {code_out[3],code_out[1]}
signal_Q  output  2  signed Q level = {code_out[2],code_out[0]}
sym_stb  output  1  one-cycle pulse on the first clock of each new symbol
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse: payload completed normally
underrun  output  1  one-cycle pulse: frame aborted, no byte available

Behaviour:
- Reset values:
  - code_out=0, signal_I=0, signal_Q=0.
  - sym_stb=0, busy=0, frame_done=0, underrun=0.
  - Period counter=0, holding register empty (in_ready=1), state=IDLE.
- Symbol timing:
  - Period counter counts 0..SYM_PERIOD-1 and wraps. It runs in every state, so the symbol grid is continuous.
  - "Boundary" means the clock edge where counter==SYM_PERIOD-1.
  - code_out changes only at boundaries.
  - sym_stb is registered and high during the cycle after each boundary.
- Input handshake:
  - in_ready = ~hold_full (combinational from the flop).
  - Accept loads in_data into the holding register and sets hold_full.
  - Accepts are allowed in any state, including prefetch in IDLE/GAP.
  - Accept and consume never occur on the same edge, because consuming requires hold_full=1.
- States:
  - IDLE:
    - code_out=IDLE_SYM (0000, zero amplitude).
    - At a boundary with enable & hold_full: go to PREAMBLE, code_out=PRE_SYM0, symbol index=0.
  - PREAMBLE:
    - Codes alternate PRE_SYM0, PRE_SYM1 by symbol index parity, for PRE_LEN symbols.
    - The last preamble boundary enters PAYLOAD and fetches the first byte.
  - PAYLOAD, even symbols (high nibble):
    - If hold_full: code_out=hold[7:4], hold[3:0] goes to the low-nibble register, hold_full clears.
    - If empty: code_out=IDLE_SYM, underrun pulses, go to GAP.
  - PAYLOAD, odd symbols (low nibble):
    - code_out=stored low nibble.
    - On the boundary after the 2*FRAME_BYTES-th payload symbol: go to GAP, code_out=IDLE_SYM, frame_done pulses.
  - GAP:
    - GAP_LEN symbols of IDLE_SYM, then IDLE.
    - The IDLE start condition is evaluated at the next boundary, not the same one.
- Latency: from a byte accepted in IDLE (enable=1) to the first preamble code is at most SYM_PERIOD+1 clocks.
- enable is sampled only in IDLE at a boundary. Deassertion mid-frame completes the frame.
- Reset mid-operation returns all outputs to their reset values on the next edge and discards the held byte and low nibble.
- All pulse outputs are registered and exactly one cycle wide.

Decomposition:
- Package qam16_pkg holds:
  - state enum: IDLE, PREAMBLE, PAYLOAD, GAP
  - IDLE_SYM=4'b0000, PRE_SYM0=4'b1001, PRE_SYM1=4'b0110
  - I/Q extraction helper functions
- Sub-module qam16_sym_timer: the SYM_PERIOD counter producing the boundary flag and registered sym_stb. It is reused by the matching receive-side controller.

Test Plan:
(Parameters for all scenarios: SYM_PERIOD=4, PRE_LEN=2, FRAME_BYTES=2, GAP_LEN=1.)
1. Reset for 3 cycles, then idle 20 cycles:
   - code_out=0 and in_ready=1 throughout.
   - busy=0.
   - sym_stb high exactly every 4th cycle.
2. enable=1, send bytes 0xA5 then 0x3C:
   - Codes at successive boundaries: 9,6,A,5,3,C,0.
   - frame_done pulses once, with the 0.
   - signal_I/signal_Q for A = 2'b11/2'b00.
   - busy falls after the gap.
3. Send 0xA5 only:
   - Codes 9,6,A,5,0.
   - underrun pulses at the boundary emitting the 0; frame_done never pulses.
   - GAP then IDLE.
4. enable=0 with 0x11 held:
   - Stays IDLE, code 0, in_ready=0.
   - Raise enable mid-symbol: PRE_SYM0 appears at the next boundary.
5. Assert reset during the PAYLOAD low-nibble symbol: the next cycle shows all reset values, in_ready=1 and state IDLE.
6. in_valid held high continuously with an incrementing data counter:
   - Exactly 2 handshakes per frame.
   - No byte duplicated or skipped across 3 back-to-back frames.

Source files
------------

// File: rtl/qam16_tx_ctrl_pkg.sv
// qam16_pkg: shared types and constants for the 16QAM framing controllers.
// Holds the controller state enum, the fixed symbol codes and I/Q extraction helpers.
package qam16_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      PAYLOAD,
      GAP
   } state_t;

   localparam logic [3:0] IDLE_SYM = 4'b0000;
   localparam logic [3:0] PRE_SYM0 = 4'b1001;
   localparam logic [3:0] PRE_SYM1 = 4'b0110;

   // I level is the signed pair {b3,b1}
   function automatic logic [1:0] sym_i(input logic [3:0] c);
      return {c[3], c[1]};
   endfunction

   // Q level is the signed pair {b2,b0}
   function automatic logic [1:0] sym_q(input logic [3:0] c);
      return {c[2], c[0]};
   endfunction

endpackage

// File: rtl/qam16_tx_ctrl_if.sv
// qam16_tx_ctrl_if: payload byte handshake into the 16QAM transmit controller.
// Ports: in_data/in_valid from the source (master), in_ready from the controller (slave).
interface qam16_tx_ctrl_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/qam16_tx_ctrl_sym_timer.sv
// qam16_sym_timer: free-running symbol period counter shared by tx and rx controllers.
// Ports: clk, reset (sync, high) in; boundary (last clock of symbol), sym_stb (registered) out.
module qam16_sym_timer #(
   parameter int SYM_PERIOD = 16
) (
   input  logic clk,
   input  logic reset,
   output logic boundary,
   output logic sym_stb
);

   localparam int CW = $clog2(SYM_PERIOD);

   logic [CW-1:0] cnt;

   assign boundary = (cnt == CW'(SYM_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         sym_stb <= 1'b0;
      end else begin
         sym_stb <= boundary;
         cnt     <= boundary ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/qam16_tx_ctrl.sv
// qam16_tx_ctrl: frames payload bytes into preamble/payload/gap symbol sequences.
// Ports: clk, reset, enable, src (byte handshake) in; code_out, I/Q levels, sym_stb, busy, frame_done, underrun out.
module qam16_tx_ctrl
   import qam16_pkg::*;
#(
   parameter int SYM_PERIOD  = 16,
   parameter int PRE_LEN     = 8,
   parameter int FRAME_BYTES = 32,
   parameter int GAP_LEN     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   qam16_tx_ctrl_if.slave src,
   output logic [3:0] code_out,
   output logic [1:0] signal_I,
   output logic [1:0] signal_Q,
   output logic       sym_stb,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int PAY_LEN = 2 * FRAME_BYTES;
   localparam int M1      = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
   localparam int IDX_MAX = (M1 > GAP_LEN) ? M1 : GAP_LEN;
   localparam int IW      = $clog2(IDX_MAX + 1);

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [3:0]    code, code_n;
   logic [7:0]    hold, hold_n;
   logic          hold_full, full_n;
   logic [3:0]    lo, lo_n;
   logic          done_n, udr_n;
   logic          fetch;
   logic          accept;
   logic          boundary;

   qam16_sym_timer #(
      .SYM_PERIOD(SYM_PERIOD)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .boundary (boundary),
      .sym_stb  (sym_stb)
   );

   assign src.in_ready = ~hold_full;
   assign accept       = src.in_valid & ~hold_full;

   assign code_out = code;
   assign signal_I = sym_i(code);
   assign signal_Q = sym_q(code);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         code       <= IDLE_SYM;
         hold       <= '0;
         hold_full  <= 1'b0;
         lo         <= '0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         code       <= code_n;
         hold       <= hold_n;
         hold_full  <= full_n;
         lo         <= lo_n;
         frame_done <= done_n;
         underrun   <= udr_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      code_n  = code;
      hold_n  = hold;
      full_n  = hold_full;
      lo_n    = lo;
      done_n  = 1'b0;
      udr_n   = 1'b0;
      fetch   = 1'b0;

      // accept needs an empty register, a successful fetch a full one,
      // so the two updates below never collide
      if (accept) begin
         hold_n = src.in_data;
         full_n = 1'b1;
      end

      if (boundary) begin
         unique case (state)
            IDLE: begin
               code_n = IDLE_SYM;
               if (enable && hold_full) begin
                  state_n = PREAMBLE;
                  idx_n   = '0;
                  code_n  = PRE_SYM0;
               end
            end
            PREAMBLE: begin
               if (idx == IW'(PRE_LEN - 1)) begin
                  state_n = PAYLOAD;
                  idx_n   = '0;
                  fetch   = 1'b1;
               end else begin
                  idx_n  = idx + 1'b1;
                  code_n = idx[0] ? PRE_SYM0 : PRE_SYM1;
               end
            end
            PAYLOAD: begin
               if (idx == IW'(PAY_LEN - 1)) begin
                  state_n = GAP;
                  idx_n   = '0;
                  code_n  = IDLE_SYM;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + 1'b1;
                  if (idx[0]) begin
                     fetch = 1'b1;
                  end else begin
                     code_n = lo;
                  end
               end
            end
            GAP: begin
               code_n = IDLE_SYM;
               // return to IDLE only; a new start waits for the next boundary
               if (idx == IW'(GAP_LEN - 1)) begin
                  state_n = IDLE;
                  idx_n   = '0;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               code_n  = IDLE_SYM;
            end
         endcase

         // high-nibble symbol: take the held byte or abort the frame
         if (fetch) begin
            if (hold_full) begin
               code_n = hold[7:4];
               lo_n   = hold[3:0];
               full_n = 1'b0;
            end else begin
               code_n  = IDLE_SYM;
               udr_n   = 1'b1;
               state_n = GAP;
               idx_n   = '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_qam16_tx_ctrl.sv
// tb_qam16_tx_ctrl: directed bench with a frame-position reference model.
// Drives the byte handshake and enable, compares every cycle and pins key sequences.
module tb_qam16_tx_ctrl;

   localparam int SP    = 4;
   localparam int PL    = 2;
   localparam int FB    = 2;
   localparam int GL    = 1;
   localparam int F_END = PL + 2 * FB + GL;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] code_out;
   logic [1:0] signal_I;
   logic [1:0] signal_Q;
   logic       sym_stb;
   logic       busy;
   logic       frame_done;
   logic       underrun;

   qam16_tx_ctrl_if bus ();

   qam16_tx_ctrl #(
      .SYM_PERIOD (SP),
      .PRE_LEN    (PL),
      .FRAME_BYTES(FB),
      .GAP_LEN    (GL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .src       (bus),
      .code_out  (code_out),
      .signal_I  (signal_I),
      .signal_Q  (signal_Q),
      .sym_stb   (sym_stb),
      .busy      (busy),
      .frame_done(frame_done),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_pos: position inside the frame (-1 when idle); symbols are
   // [0,PL) preamble, [PL,PL+2FB) payload, [PL+2FB,F_END) gap
   int         m_tick;
   int         m_pos;
   logic [7:0] m_q[$];
   logic [3:0] m_code;
   logic [3:0] m_lo;
   bit         m_stb, m_done, m_udr;
   bit         m_live = 0;

   task automatic model_boundary();
      logic [7:0] b;
      if (m_pos < 0) begin
         m_code = 4'h0;
         if (enable && m_q.size() != 0) begin
            m_pos  = 0;
            m_code = 4'h9;
         end
      end else begin
         m_pos++;
         if (m_pos == F_END) begin
            m_pos  = -1;
            m_code = 4'h0;
         end else if (m_pos < PL) begin
            m_code = (m_pos % 2 == 1) ? 4'h6 : 4'h9;
         end else if (m_pos < PL + 2 * FB) begin
            if ((m_pos - PL) % 2 == 0) begin
               if (m_q.size() == 0) begin
                  m_udr  = 1;
                  m_code = 4'h0;
                  m_pos  = PL + 2 * FB;
               end else begin
                  b      = m_q.pop_front();
                  m_code = b[7:4];
                  m_lo   = b[3:0];
               end
            end else begin
               m_code = m_lo;
            end
         end else begin
            m_code = 4'h0;
            if (m_pos == PL + 2 * FB) m_done = 1;
         end
      end
   endtask

   always @(posedge clk) begin : model
      bit acc;
      bit bnd;
      m_live = 1;
      if (reset) begin
         m_tick = 0;
         m_pos  = -1;
         m_q.delete();
         m_code = 4'h0;
         m_lo   = 4'h0;
         m_stb  = 0;
         m_done = 0;
         m_udr  = 0;
      end else begin
         acc    = bus.in_valid && (m_q.size() == 0);
         bnd    = (m_tick % SP) == SP - 1;
         m_tick++;
         m_stb  = bnd;
         m_done = 0;
         m_udr  = 0;
         if (bnd) model_boundary();
         if (acc) m_q.push_back(bus.in_data);
      end
   end

   always @(negedge clk) begin : compare
      if (m_live) begin
         check("code_out", code_out, m_code);
         check("signal_I", signal_I, {m_code[3], m_code[1]});
         check("signal_Q", signal_Q, {m_code[2], m_code[0]});
         check("sym_stb", sym_stb, m_stb);
         check("busy", busy, m_pos >= 0);
         check("frame_done", frame_done, m_done);
         check("underrun", underrun, m_udr);
         check("in_ready", bus.in_ready, m_q.size() == 0);
      end
   end

   // ---------------- monitors ----------------
   logic [3:0] cap[$];
   logic [1:0] cap_i[$];
   logic [1:0] cap_q[$];
   logic [7:0] hs_q[$];
   int         n_stb = 0;
   int         n_done = 0;
   int         n_udr = 0;
   logic [3:0] udr_code;

   always @(negedge clk) begin
      if (sym_stb) begin
         n_stb++;
         if (busy) begin
            cap.push_back(code_out);
            cap_i.push_back(signal_I);
            cap_q.push_back(signal_Q);
         end
      end
      if (frame_done) n_done++;
      if (underrun) begin
         n_udr++;
         udr_code = code_out;
      end
   end

   always @(posedge clk) begin
      if (!reset && bus.in_valid && bus.in_ready) hs_q.push_back(bus.in_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      while (!bus.in_ready && t < 200) begin
         tick();
         t++;
      end
      check("send_ready_wait", t < 200, 1);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl);
      int t = 0;
      while (busy !== lvl && t < 500) begin
         tick();
         t++;
      end
      check("busy_wait", t < 500, 1);
   endtask

   task automatic clear_logs();
      cap.delete();
      cap_i.delete();
      cap_q.delete();
      n_done = 0;
      n_udr  = 0;
   endtask

   task automatic check_codes(input string name, input logic [3:0] exp[$]);
      check({name, "_len"}, cap.size(), exp.size());
      for (int i = 0; i < exp.size() && i < cap.size(); i++)
         check(name, cap[i], exp[i]);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int         stb_at[$];
      int         t;
      int         base;
      logic [3:0] e2[$];
      logic [3:0] e3[$];
      logic [7:0] b;

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset        = 1'b1;
      enable       = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t1_code", code_out, 4'h0);
         check("t1_ready", bus.in_ready, 1'b1);
         check("t1_busy", busy, 1'b0);
         if (sym_stb) stb_at.push_back(i);
      end
      check("t1_stb_count", stb_at.size(), 5);
      for (int i = 1; i < stb_at.size(); i++)
         check("t1_stb_spacing", stb_at[i] - stb_at[i-1], SP);

      // 2: complete frame A5, 3C
      clear_logs();
      enable = 1'b1;
      send(8'hA5);
      send(8'h3C);
      wait_busy(1'b0);
      e2 = '{4'h9, 4'h6, 4'hA, 4'h5, 4'h3, 4'hC, 4'h0};
      check_codes("t2_codes", e2);
      if (cap.size() > 2) begin
         check("t2_I_of_A", cap_i[2], 2'b11);
         check("t2_Q_of_A", cap_q[2], 2'b00);
      end
      check("t2_done_count", n_done, 1);
      check("t2_udr_count", n_udr, 0);

      // 3: single byte -> underrun
      clear_logs();
      send(8'hA5);
      wait_busy(1'b1);
      wait_busy(1'b0);
      e3 = '{4'h9, 4'h6, 4'hA, 4'h5, 4'h0};
      check_codes("t3_codes", e3);
      check("t3_udr_count", n_udr, 1);
      check("t3_udr_code", udr_code, 4'h0);
      check("t3_done_count", n_done, 0);

      // 4: enable low holds the frame back
      clear_logs();
      enable = 1'b0;
      send(8'h11);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t4_busy", busy, 1'b0);
         check("t4_code", code_out, 4'h0);
         check("t4_ready", bus.in_ready, 1'b0);
      end
      t = 0;
      while (!sym_stb && t < 20) begin
         tick();
         t++;
      end
      tick();
      enable = 1'b1;
      t = 0;
      while (!sym_stb && t < 20) begin
         tick();
         t++;
      end
      check("t4_start_latency", t <= SP, 1);
      check("t4_first_code", code_out, 4'h9);

      // 5: reset during the low-nibble symbol with a byte held
      base = n_stb;
      send(8'h22);
      t = 0;
      while (n_stb < base + 3 && t < 50) begin
         tick();
         t++;
      end
      check("t5_reach_low", t < 50, 1);
      check("t5_low_code", code_out, 4'h1);
      check("t5_held", bus.in_ready, 1'b0);
      reset = 1'b1;
      tick();
      check("t5_code", code_out, 4'h0);
      check("t5_I", signal_I, 2'b00);
      check("t5_Q", signal_Q, 2'b00);
      check("t5_stb", sym_stb, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", frame_done, 1'b0);
      check("t5_udr", underrun, 1'b0);
      check("t5_ready", bus.in_ready, 1'b1);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t5_stays_idle", busy, 1'b0);
      end

      // 6: continuous source over three frames
      clear_logs();
      hs_q.delete();
      enable       = 1'b1;
      bus.in_valid = 1'b1;
      t = 0;
      while (n_done < 3 && t < 2000) begin
         bus.in_data = 8'(8'h40 + hs_q.size());
         tick();
         t++;
      end
      enable       = 1'b0;
      bus.in_valid = 1'b0;
      check("t6_three_frames", t < 2000, 1);
      wait_busy(1'b0);
      check("t6_handshakes", hs_q.size(), 3 * FB + 1);
      for (int i = 0; i < hs_q.size(); i++)
         check("t6_hs_data", hs_q[i], 8'(8'h40 + i));
      check("t6_cap_len", cap.size(), 3 * F_END);
      check("t6_udr_count", n_udr, 0);
      if (cap.size() == 3 * F_END) begin
         for (int f = 0; f < 3; f++) begin
            check("t6_pre0", cap[f*F_END], 4'h9);
            check("t6_pre1", cap[f*F_END+1], 4'h6);
            b = {cap[f*F_END+2], cap[f*F_END+3]};
            check("t6_byte0", b, 8'(8'h40 + 2 * f));
            b = {cap[f*F_END+4], cap[f*F_END+5]};
            check("t6_byte1", b, 8'(8'h41 + 2 * f));
            check("t6_gap", cap[f*F_END+6], 4'h0);
         end
      end

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
